uart_rx_buffered: RTL and testbench
===================================

Name: uart_rx_buffered

Overview:
- UART receiver for the FPGA side of the FTDI link: deserialises `serial_rxd` (8N1, LSB first) into bytes.
- Presents each byte through a one-entry holding register with a valid/ready handshake.
- Counterpart of the team's serial transmit path; sits between the `serial_rxd` pin and user logic (e.g. LED/PWM control).
- Flags framing errors and overruns as single-cycle pulses.

Parameters:
- CLOCK_FREQ, 10_000_000, system clock frequency in Hz.
- BAUD, 115200, line rate in bit/s.
- CLOCKS_PER_BIT, CLOCK_FREQ / BAUD, clocks per bit period (86 at defaults); must be >= 4.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- rxd  input  1  raw serial line; idle high; asynchronous to clk.
- data  output  8  received byte, stable while valid=1.
- valid  output  1  holding register full.
- ready  input  1  consumer accepts data when valid&&ready.
- frame_err  output  1  one-cycle pulse: stop bit sampled low.
- overrun  output  1  one-cycle pulse: byte completed while holding register full and not being drained.
- parity_err  output  1  one-cycle pulse: parity mismatch (tied 0 without the optional feature).
- busy  output  1  receiver FSM not in IDLE.

Behaviour:
- Reset values (async assert, sync deassert by the surrounding design): data=0x00, valid=0, frame_err=0, overrun=0, parity_err=0, busy=0.
  - FSM=IDLE, counters=0, synchroniser flops=1.
- Synchroniser: rxd passes through 2 flops (rxd_s); all decisions use rxd_s only.
- Bit counter: cnt counts 0..CLOCKS_PER_BIT-1 and is zeroed on every state entry.
- Bit index: idx counts 0..7.
- FSM states:
  - IDLE: busy=0. When rxd_s==0, go to START, cnt=0.
  - START: at cnt==CLOCKS_PER_BIT/2-1 (integer divide), sample rxd_s.
    - 0: go to DATA, idx=0.
    - 1: glitch; go to IDLE with no flag.
  - DATA: every CLOCKS_PER_BIT clocks, sample rxd_s into shift[idx] (LSB first).
    - After idx==7: go to PARITY if the feature is enabled, else STOP.
  - PARITY (feature only): sample one bit after CLOCKS_PER_BIT clocks, then go to STOP.
  - STOP: sample after CLOCKS_PER_BIT clocks.
    - 1: commit byte (see below), go to IDLE.
    - 0: pulse frame_err, discard byte, go to BREAK.
  - BREAK: wait until rxd_s==1, then go to IDLE. A held-low line produces exactly one frame_err.
- Commit, on the cycle after the stop sample:
  - If valid==0, or valid&&ready in that same cycle: data<=shift, valid<=1.
  - Otherwise: keep the old data, pulse overrun, drop the new byte.
- Handshake:
  - valid falls the cycle after valid&&ready, unless a commit occurs in that cycle (then valid stays 1 with the new data).
  - data must not change while valid=1 and ready=0.
- Latency: valid rises CLOCKS_PER_BIT/2 + 9*CLOCKS_PER_BIT + 1 clocks after rxd_s first reads 0 (add CLOCKS_PER_BIT with parity).
  - Add 2 clocks from the rxd pin because of the synchroniser.
- Back-to-back frames: a start bit immediately after the stop sample is detected. IDLE is entered half a bit before the stop bit ends, so no frame is lost.
- Async reset mid-frame: the partial byte is discarded and outputs return to reset values immediately. The next falling edge of rxd_s starts a fresh frame.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - Frame is 8E1; the PARITY state is inserted.
  - Even parity: XOR of the 8 data bits and the parity bit must equal 0.
  - On mismatch, pulse parity_err in the commit cycle and discard the byte (no valid, no overrun).
  - The stop bit is still checked; if both errors occur, only frame_err pulses.
- Undefined: 8N1 only; PARITY state and logic absent; parity_err tied 0.

Test Plan:
- Single byte, CLOCKS_PER_BIT=8, ready=1: drive 0xA5 8N1 -> valid for 1 cycle with data=0xA5; latency 4+72+1+2 = 79 clocks from the rxd falling edge.
- Glitch: rxd low for 3 clocks, then high -> FSM returns to IDLE; valid, frame_err and busy end at 0; no byte.
- Framing: 0x3C with stop bit low for 2 bit times -> exactly one frame_err pulse, valid stays 0; the following good 0x81 is received correctly.
- Overrun: ready=0, send 0x11 then 0x22 back-to-back -> data=0x11 held, one overrun pulse; raising ready later shows 0x11, then valid=0.
- Simultaneous drain/commit: assert ready on exactly the commit cycle of a second byte 0x55 -> valid stays 1, data becomes 0x55, no overrun.
- Reset mid-frame (after 4 data bits), then send 0x0F -> outputs at reset values during rst; 0x0F is received correctly. With UART_RX_PARITY_EN: 0x0F with parity=1 -> parity_err pulse, no valid.

Source files
------------

// File: rtl/uart_rx_buffered.sv
// UART receiver (8N1, LSB first) feeding a one-entry valid/ready holding register.
// Optional macro UART_RX_PARITY_EN switches to 8E1 frames with even-parity checking.
module uart_rx_buffered #(
  parameter int CLOCK_FREQ     = 10_000_000,
  parameter int BAUD           = 115200,
  parameter int CLOCKS_PER_BIT = CLOCK_FREQ / BAUD
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  output logic [7:0] data,
  output logic       valid,
  input  logic       ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       parity_err,
  output logic       busy
);
  localparam int CW = $clog2(CLOCKS_PER_BIT);
  localparam logic [CW-1:0] CNT_HALF = CW'(CLOCKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLOCKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP,
    S_BREAK
  } state_t;

  state_t        state;
  logic [1:0]    sync_q;
  logic          rxd_s;
  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic [7:0]    shift;
  logic          stop_ok;   // good stop bit seen; commit happens next cycle
  logic          byte_ok;

  // Two-flop synchroniser; idles high so reset never looks like a start bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= 2'b11;
    else     sync_q <= {sync_q[0], rxd};
  end
  assign rxd_s = sync_q[1];

`ifdef UART_RX_PARITY_EN
  logic par_bit;
  logic par_ok;
  assign byte_ok = par_ok;
`else
  assign byte_ok = 1'b1;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      idx       <= '0;
      shift     <= '0;
      busy      <= 1'b0;
      frame_err <= 1'b0;
      stop_ok   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit   <= 1'b0;
      par_ok    <= 1'b1;
`endif
    end else begin
      frame_err <= 1'b0;
      stop_ok   <= 1'b0;
      cnt       <= cnt + 1'b1;
      case (state)
        S_IDLE: begin
          cnt <= '0;
          if (!rxd_s) begin
            state <= S_START;
            busy  <= 1'b1;
          end
        end
        S_START: if (cnt == CNT_HALF) begin
          cnt <= '0;
          if (rxd_s) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else begin
            state <= S_DATA;
            idx   <= '0;
          end
        end
        S_DATA: if (cnt == CNT_LAST) begin
          cnt        <= '0;
          shift[idx] <= rxd_s;
          idx        <= idx + 3'd1;
`ifdef UART_RX_PARITY_EN
          if (idx == 3'd7) state <= S_PARITY;
`else
          if (idx == 3'd7) state <= S_STOP;
`endif
        end
`ifdef UART_RX_PARITY_EN
        S_PARITY: if (cnt == CNT_LAST) begin
          cnt     <= '0;
          par_bit <= rxd_s;
          state   <= S_STOP;
        end
`endif
        S_STOP: if (cnt == CNT_LAST) begin
          cnt <= '0;
          if (rxd_s) begin
            // Back to IDLE half a bit early so an immediate start bit is caught.
            stop_ok <= 1'b1;
            state   <= S_IDLE;
            busy    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_ok  <= ~(^{shift, par_bit});
`endif
          end else begin
            frame_err <= 1'b1;
            state     <= S_BREAK;
          end
        end
        S_BREAK: begin
          cnt <= '0;
          if (rxd_s) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Holding register: a commit may coincide with a drain and wins over it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data    <= 8'h00;
      valid   <= 1'b0;
      overrun <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (valid && ready) valid <= 1'b0;
      if (stop_ok && byte_ok) begin
        if (!valid || ready) begin
          data  <= shift;
          valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) parity_err <= 1'b0;
    else     parity_err <= stop_ok & ~byte_ok;
  end
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_buffered.sv
// Bench for uart_rx_buffered: directed frames plus a per-cycle holding-register model.
module tb_uart_rx_buffered;
  localparam int CPB = 8;
`ifdef UART_RX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  // rxd is driven at a falling clk edge N; it is captured at rising edge N+1 and,
  // 79 edges later (4 + 72 + 1 + 2), valid appears after rising edge N+80.
  localparam int COMMIT_OFS = NBITS * CPB;
  localparam int STOP_OFS   = COMMIT_OFS - 1;

  logic       clk = 1'b0, rst = 1'b1, rxd = 1'b1, ready = 1'b0;
  logic [7:0] data;
  logic       valid, frame_err, overrun, parity_err, busy;

  uart_rx_buffered #(.CLOCK_FREQ(800), .BAUD(100), .CLOCKS_PER_BIT(CPB)) dut (
    .clk(clk), .rst(rst), .rxd(rxd), .data(data), .valid(valid), .ready(ready),
    .frame_err(frame_err), .overrun(overrun), .parity_err(parity_err), .busy(busy)
  );

  always #5 clk = ~clk;

  // kind: 0 good byte, 1 framing error, 2 parity error
  typedef struct { int at; int kind; logic [7:0] b; } ev_t;
  ev_t evq[$];

  int tests = 0, fails = 0, cyc = 0;
  int n_ferr = 0, n_ovr = 0, n_perr = 0, rise_cyc = 0;
  logic [7:0] rise_data = 8'h00;
  logic       mv = 1'b0, pv = 1'b0;
  logic [7:0] md = 8'h00;
  logic       e_ovr, e_ferr, e_perr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: frames become timed events; holding register follows the handshake rules.
  initial begin : cmp
    logic rdy_e, rst_e, mv_old;
    forever begin
      @(posedge clk);
      cyc++;
      rdy_e = ready;
      rst_e = rst;
      e_ovr = 1'b0; e_ferr = 1'b0; e_perr = 1'b0;
      if (rst_e) begin
        mv = 1'b0; md = 8'h00; evq.delete();
      end else begin
        mv_old = mv;
        if (mv && rdy_e) mv = 1'b0;
        if (evq.size() > 0 && evq[0].at == cyc) begin
          case (evq[0].kind)
            0: if (!mv_old || rdy_e) begin mv = 1'b1; md = evq[0].b; end
               else e_ovr = 1'b1;
            1: e_ferr = 1'b1;
            default: e_perr = 1'b1;
          endcase
          void'(evq.pop_front());
        end
      end
      #2;
      chk("valid", valid, mv);
      chk("data", data, md);
      chk("overrun", overrun, e_ovr);
      chk("frame_err", frame_err, e_ferr);
      chk("parity_err", parity_err, e_perr);
      if (valid && !pv) begin rise_cyc = cyc; rise_data = data; end
      pv = valid;
      n_ferr += int'(frame_err);
      n_ovr  += int'(overrun);
      n_perr += int'(parity_err);
    end
  end

  task automatic hold(input logic v, input int bits);
    rxd = v;
    repeat (bits * CPB) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b, input int stop_low = 0, input logic pflip = 1'b0);
    ev_t e;
    e.b = b;
    if (stop_low > 0) begin e.at = cyc + STOP_OFS;   e.kind = 1; end
    else              begin e.at = cyc + COMMIT_OFS; e.kind = pflip ? 2 : 0; end
    evq.push_back(e);
    hold(1'b0, 1);
    for (int i = 0; i < 8; i++) hold(b[i], 1);
`ifdef UART_RX_PARITY_EN
    hold(^b ^ pflip, 1);
`endif
    if (stop_low > 0) hold(1'b0, stop_low);
    hold(1'b1, 1);
  endtask

  initial begin : stim
    int t0, f0, o0;
    logic [7:0] part;
    repeat (3) @(negedge clk);
    chk("rst_data", data, 8'h00);
    chk("rst_valid", valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_pulses", {frame_err, overrun, parity_err}, 0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // single byte, ready held high
    ready = 1'b1; t0 = cyc;
    send(8'hA5);
    hold(1'b1, 1);
    chk("lat_a5", rise_cyc - (t0 + 1), COMMIT_OFS - 1);
    chk("data_a5", rise_data, 8'hA5);
    chk("a5_drained", valid, 0);

    // glitch: three clocks low
    f0 = n_ferr; t0 = rise_cyc;
    rxd = 1'b0;
    repeat (3) @(negedge clk);
    chk("glitch_busy_mid", busy, 1);
    rxd = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    chk("glitch_busy", busy, 0);
    chk("glitch_valid", valid, 0);
    chk("glitch_ferr", n_ferr - f0, 0);
    chk("glitch_no_byte", rise_cyc, t0);

    // framing error: stop low for two bit times, then a good byte
    f0 = n_ferr; t0 = rise_cyc;
    send(8'h3C, 2);
    chk("ferr_count", n_ferr - f0, 1);
    chk("ferr_no_byte", rise_cyc, t0);
    send(8'h81);
    hold(1'b1, 1);
    chk("rx_81", rise_data, 8'h81);

    // overrun: consumer stalled across two back-to-back bytes
    ready = 1'b0; o0 = n_ovr;
    send(8'h11);
    send(8'h22);
    hold(1'b1, 1);
    chk("ovr_count", n_ovr - o0, 1);
    chk("ovr_valid", valid, 1);
    chk("ovr_data", data, 8'h11);
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    chk("ovr_drained", valid, 0);
    chk("ovr_data_kept", data, 8'h11);

    // drain on exactly the commit cycle of the second byte
    o0 = n_ovr;
    send(8'h44);
    fork
      send(8'h55);
      begin
        repeat (COMMIT_OFS - 1) @(negedge clk);
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
      end
    join
    chk("swap_valid", valid, 1);
    chk("swap_data", data, 8'h55);
    chk("swap_no_ovr", n_ovr - o0, 0);

    // reset after four data bits of 0x0F, with 0x55 still held
    part = 8'h0F;
    hold(1'b1, 1);
    hold(1'b0, 1);
    for (int i = 0; i < 4; i++) hold(part[i], 1);
    chk("mid_busy", busy, 1);
    rst = 1'b1; rxd = 1'b1;
    #1;
    chk("mid_rst_valid", valid, 0);
    chk("mid_rst_data", data, 8'h00);
    chk("mid_rst_busy", busy, 0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    ready = 1'b1;
    send(8'h0F);
    hold(1'b1, 1);
    chk("rx_0f", rise_data, 8'h0F);

`ifdef UART_RX_PARITY_EN
    f0 = n_perr; t0 = rise_cyc;
    send(8'h0F, 0, 1'b1);
    hold(1'b1, 1);
    chk("perr_count", n_perr - f0, 1);
    chk("perr_no_byte", rise_cyc, t0);
`endif

    hold(1'b1, 1);
    chk("events_done", evq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1);
  end
endmodule
